// File: rtl/conv_frame_ctrl_if.sv
// rtl/conv_frame_ctrl_if.sv - pixel/control/tag bundle between upstream, sequencer and convolution datapath
interface conv_frame_ctrl_if #(
    parameter int PIXEL_SIZE = 12
);
    logic                      in_valid;
    logic                      in_sof;
    logic [PIXEL_SIZE-1:0]     in_pixel;
    logic                      in_ready;
    logic [1:0]                filter_sel;
    logic                      conv_valid;
    logic [PIXEL_SIZE-1:0]     conv_pixel;
    logic [9*PIXEL_SIZE-1:0]   conv_filter;
    logic                      out_valid;
    logic                      out_sof;
    logic                      out_eol;
    logic                      out_eof;
    logic                      frame_done;
    logic                      frame_err;

    // Upstream / environment side: drives pixels and filter choice, observes everything else.
    modport master (
        output in_valid, in_sof, in_pixel, filter_sel,
        input  in_ready, conv_valid, conv_pixel, conv_filter,
        input  out_valid, out_sof, out_eol, out_eof, frame_done, frame_err
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_sof, in_pixel, filter_sel,
        output in_ready, conv_valid, conv_pixel, conv_filter,
        output out_valid, out_sof, out_eol, out_eof, frame_done, frame_err
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// rtl/conv_frame_ctrl.sv - frame sequencer, window tagger and coefficient driver for the 3x3 convolution datapath
module conv_frame_ctrl #(
    parameter int PIXEL_SIZE = 12,
    parameter int ROW_SIZE   = 640,
    parameter int NUM_ROWS   = 480
) (
    input  logic                 clk,
    input  logic                 rst_n,
    conv_frame_ctrl_if.slave     bus
);
    localparam int CW = $clog2(ROW_SIZE);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int FW = 9 * PIXEL_SIZE;

    localparam logic [CW-1:0] COL_LAST = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Coefficient set for a filter select; slot i*3+j holds filter[i-1][j-1], sign-extended.
    function automatic logic [FW-1:0] coeffs(input logic [1:0] sel);
        int k [9];
        logic [FW-1:0] v;
        case (sel)
            2'd1:    k = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
            2'd2:    k = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
            2'd3:    k = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
            default: k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        endcase
        v = '0;
        for (int i = 0; i < 9; i++) begin
            v[i*PIXEL_SIZE +: PIXEL_SIZE] = PIXEL_SIZE'(k[i]);
        end
        return v;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [FW-1:0]   filter_q, filter_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sof_q, out_sof_d;
    logic            out_eol_q, out_eol_d;
    logic            out_eof_q, out_eof_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_err_q, frame_err_d;

    logic            in_ready;
    logic            accept;

    assign in_ready = (state_q != DONE);
    assign accept   = bus.in_valid & in_ready;

    // Datapath feed: only pixels belonging to a frame reach the convolution datapath.
    assign bus.in_ready    = in_ready;
    assign bus.conv_valid  = accept & ((state_q == RUN) | bus.in_sof);
    assign bus.conv_pixel  = bus.in_pixel;
    assign bus.conv_filter = filter_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sof     = out_sof_q;
    assign bus.out_eol     = out_eol_q;
    assign bus.out_eof     = out_eof_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_err   = frame_err_q;

    // Next-state: raster position, frame FSM, filter latch and window tags for the accepted pixel.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        filter_d     = filter_q;
        out_valid_d  = 1'b0;
        out_sof_d    = 1'b0;
        out_eol_d    = 1'b0;
        out_eof_d    = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Pixels without a start-of-frame are dropped until a frame begins.
                if (accept && bus.in_sof) begin
                    col_d    = CW'(1);
                    row_d    = '0;
                    filter_d = coeffs(bus.filter_sel);
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        // Restart: this pixel becomes (0,0) of a new frame.
                        frame_err_d = (row_q != '0) || (col_q != '0);
                        col_d       = CW'(1);
                        row_d       = '0;
                        filter_d    = coeffs(bus.filter_sel);
                    end else begin
                        // Window centred one row up and one column left; columns 0/1 straddle rows.
                        out_valid_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
                        out_sof_d   = (row_q == ROW_TWO) && (col_q == COL_TWO);
                        out_eol_d   = out_valid_d && (col_q == COL_LAST);
                        out_eof_d   = (row_q == ROW_LAST) && (col_q == COL_LAST);
                        if (out_eof_d) begin
                            frame_done_d = 1'b1;
                            col_d        = '0;
                            row_d        = '0;
                            state_d      = DONE;
                        end else if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset returns everything to idle/identity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            filter_q     <= coeffs(2'd0);
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            filter_q     <= filter_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb/tb_conv_frame_ctrl.sv - scoreboard bench for conv_frame_ctrl on a 4x3 frame
module tb_conv_frame_ctrl;
    localparam int PS = 12;
    localparam int RS = 4;
    localparam int NR = 3;
    localparam int FW = 9 * PS;

    localparam logic [FW-1:0] F_ID  = 108'h000000000000001000000000000;
    localparam logic [FW-1:0] F_SX  = 108'h001000FFF002000FFE001000FFF;
    localparam logic [FW-1:0] F_SY  = 108'h001002001000000000FFFFFEFFF;
    localparam logic [FW-1:0] F_BOX = 108'h001001001001001001001001001;

    typedef struct {
        int   cyc;
        logic sof;
        logic eol;
        logic eof;
    } tag_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_done_seen = 0;
    int   n_done_exp = 0;
    tag_t tag_q[$];
    int   err_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_frame_ctrl_if #(.PIXEL_SIZE(PS)) bus();

    conv_frame_ctrl #(.PIXEL_SIZE(PS), .ROW_SIZE(RS), .NUM_ROWS(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops expected tags/errors whenever the DUT raises them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_done) n_done_seen++;
            if (bus.out_valid) begin
                if (tag_q.size() == 0) begin
                    check("unexpected_out_valid", 1'b1, 1'b0);
                end else begin
                    tag_t e;
                    e = tag_q.pop_front();
                    check("tag_cycle", FW'(cyc), FW'(e.cyc));
                    check("out_sof", bus.out_sof, e.sof);
                    check("out_eol", bus.out_eol, e.eol);
                    check("out_eof", bus.out_eof, e.eof);
                    check("frame_done_with_eof", bus.frame_done, e.eof);
                end
            end else if (bus.out_sof || bus.out_eol || bus.out_eof || bus.frame_done) begin
                check("tag_without_valid", {bus.out_sof, bus.out_eol, bus.out_eof, bus.frame_done}, 4'b0);
            end
            if (bus.frame_err) begin
                if (err_q.size() == 0) check("unexpected_frame_err", 1'b1, 1'b0);
                else check("frame_err_cycle", FW'(cyc), FW'(err_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one pixel for one cycle; optionally register the tag it must produce one cycle later.
    task automatic send_px(input logic sof, input logic [PS-1:0] pix, input logic exp_cv,
                           input logic tag, input logic t_sof, input logic t_eol, input logic t_eof);
        tag_t e;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pixel = pix;
        if (tag) begin
            e.cyc = cyc + 1;
            e.sof = t_sof;
            e.eol = t_eol;
            e.eof = t_eof;
            tag_q.push_back(e);
        end
        @(negedge clk);
        check("conv_valid", bus.conv_valid, exp_cv);
        if (exp_cv) check("conv_pixel", bus.conv_pixel, pix);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    // Full 4x3 frame: windows at pixels 10 (2,2) and 11 (2,3).
    task automatic run_frame(input logic [1:0] sel, input logic gap, input logic [FW-1:0] exp_f,
                             input logic [PS-1:0] base);
        bus.filter_sel = sel;
        for (int k = 0; k < RS * NR; k++) begin
            send_px(k == 0, base + PS'(k), 1'b1, k >= 10, k == 10, k == 11, k == 11);
            if (k == 0) begin
                check("filter_latched", bus.conv_filter, exp_f);
                bus.filter_sel = ~sel;
            end
            if (gap && k < RS * NR - 1) idle(1);
        end
        n_done_exp++;
        check("in_ready_done", bus.in_ready, 1'b0);
        idle(1);
        check("in_ready_after_done", bus.in_ready, 1'b1);
        check("filter_held", bus.conv_filter, exp_f);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_sof     = 1'b0;
        bus.in_pixel   = '0;
        bus.filter_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: reset state
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_filter", bus.conv_filter, F_ID);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_conv_valid", bus.conv_valid, 1'b0);
        @(posedge clk);
        #1;

        // 2: back-to-back frame, SobelX
        run_frame(2'd1, 1'b0, F_SX, 12'h100);

        // 3: pixels without sof in IDLE are dropped, then a box-filter frame
        bus.filter_sel = 2'd2;
        for (int k = 0; k < 3; k++) send_px(1'b0, 12'h0A0 + PS'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop_filter_unchanged", bus.conv_filter, F_SX);
        run_frame(2'd3, 1'b0, F_BOX, 12'h200);

        // 4: same frame with a bubble after every pixel, identity
        run_frame(2'd0, 1'b1, F_ID, 12'h300);

        // 5: sof at (1,2) with SobelY restarts the frame and pulses frame_err
        bus.filter_sel = 2'd1;
        for (int k = 0; k < 6; k++) send_px(k == 0, 12'h400 + PS'(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_restart_filter", bus.conv_filter, F_SX);
        bus.filter_sel = 2'd2;
        err_q.push_back(cyc + 1);
        send_px(1'b1, 12'h500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_filter", bus.conv_filter, F_SY);
        for (int k = 1; k < RS * NR; k++)
            send_px(1'b0, 12'h500 + PS'(k), 1'b1, k >= 10, k == 10, k == 11, k == 11);
        n_done_exp++;
        check("restart_in_ready_done", bus.in_ready, 1'b0);
        idle(1);

        // 6: reset after pixel (2,1): no tags or done, outputs back to reset values
        bus.filter_sel = 2'd3;
        for (int k = 0; k < 10; k++) send_px(k == 0, 12'h600 + PS'(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_out_eof", bus.out_eof, 1'b0);
        check("midrst_frame_done", bus.frame_done, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_filter", bus.conv_filter, F_ID);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        run_frame(2'd2, 1'b0, F_SY, 12'h700);

        idle(3);
        check("tags_outstanding", FW'(tag_q.size()), FW'(0));
        check("errs_outstanding", FW'(err_q.size()), FW'(0));
        check("frame_done_count", FW'(n_done_seen), FW'(n_done_exp));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
